// File: rtl/neuron_state_seq_if.sv
// Handshake and datapath bundle between a neuron_state_seq, its controller,
// the v_equation block and the spike consumer.
interface neuron_state_seq_if #(
  parameter int TICK_W = 16
);
  logic                     step;
  logic signed [10:0]       I_in;
  logic signed [31:0]       veq_v;
  logic signed [31:0]       veq_u;
  logic signed [10:0]       veq_I;
  logic signed [31:0]       veq_v_out;
  logic                     veq_spike;
  logic                     busy;
  logic                     done;
  logic                     spike_valid;
  logic                     spike_ready;
  logic        [TICK_W-1:0] spike_time;
  logic signed [31:0]       v_state;
  logic signed [31:0]       u_state;

  modport master (
    output step, I_in, veq_v_out, veq_spike, spike_ready,
    input  veq_v, veq_u, veq_I, busy, done, spike_valid, spike_time, v_state, u_state
  );

  modport slave (
    input  step, I_in, veq_v_out, veq_spike, spike_ready,
    output veq_v, veq_u, veq_I, busy, done, spike_valid, spike_time, v_state, u_state
  );
endinterface

// File: rtl/neuron_state_seq.sv
// Izhikevich per-neuron state sequencer around a combinational v_equation.
// Optional feature: define SPIKE_COUNT_EN to add a saturating spike_count output.
module neuron_state_seq #(
  parameter int V_INIT  = -650,
  parameter int U_INIT  = -130,
  parameter int D       = 80,
  parameter int A_SHIFT = 6,
  parameter int B_SHIFT = 2,
  parameter int TICK_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
`ifdef SPIKE_COUNT_EN
  output logic [15:0]        spike_count,
`endif
  neuron_state_seq_if.slave  bus
);

  localparam logic signed [31:0] V_RST = 32'(V_INIT);
  localparam logic signed [31:0] U_RST = 32'(U_INIT);
  localparam logic signed [31:0] D_INC = 32'(D);

  typedef enum logic [1:0] {IDLE, EVAL, UPDATE, EMIT} state_t;

  state_t state, state_nxt;

  logic signed [31:0] v_reg, u_reg;
  logic signed [10:0] I_reg;
  logic signed [31:0] v_new_p1;
  logic               spk_p1;
  logic [TICK_W-1:0]  tick;
  logic [TICK_W-1:0]  spike_time_r;
  logic               done_r;
  logic               spike_valid_r;
  logic               accept;
  logic               handshake;
  logic               busy_c;

  // Recovery relaxation toward b*v; both shifts floor toward -inf.
  function automatic logic signed [31:0] u_decay(input logic signed [31:0] v,
                                                 input logic signed [31:0] u);
    logic signed [31:0] diff;
    diff = (v >>> B_SHIFT) - u;
    return u + (diff >>> A_SHIFT);
  endfunction

  function automatic logic signed [31:0] u_bump(input logic signed [31:0] u);
    return u + D_INC;
  endfunction

  // A step coinciding with the done pulse is dropped, not just one while busy.
  assign accept    = (state == IDLE) && bus.step && !done_r;
  assign handshake = (state == EMIT) && bus.spike_ready;

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b1;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (accept) state_nxt = EVAL;
      end
      EVAL:    state_nxt = UPDATE;
      UPDATE:  state_nxt = spk_p1 ? EMIT : IDLE;
      EMIT:    if (bus.spike_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // EVAL -> p1: capture v_equation result; only read in UPDATE, so no reset needed.
  always_ff @(posedge clk) begin
    if (state == EVAL) begin
      v_new_p1 <= bus.veq_v_out;
      spk_p1   <= bus.veq_spike;
    end
  end

  // UPDATE: commit v/u, advance the tick, raise the event or retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_reg         <= V_RST;
      u_reg         <= U_RST;
      I_reg         <= '0;
      tick          <= '0;
      done_r        <= 1'b0;
      spike_valid_r <= 1'b0;
      spike_time_r  <= '0;
    end else begin
      done_r <= 1'b0;
      if (accept) I_reg <= bus.I_in;
      if (state == UPDATE) begin
        v_reg <= v_new_p1;
        u_reg <= spk_p1 ? u_bump(u_reg) : u_decay(v_reg, u_reg);
        tick  <= tick + 1'b1;
        if (spk_p1) begin
          spike_time_r  <= tick;
          spike_valid_r <= 1'b1;
        end else begin
          done_r <= 1'b1;
        end
      end
      if (handshake) begin
        spike_valid_r <= 1'b0;
        done_r        <= 1'b1;
      end
    end
  end

`ifdef SPIKE_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                   spike_count <= '0;
    else if (handshake && spike_count != '1)   spike_count <= spike_count + 16'd1;
  end
`endif

  assign bus.veq_v       = v_reg;
  assign bus.veq_u       = u_reg;
  assign bus.veq_I       = I_reg;
  assign bus.v_state     = v_reg;
  assign bus.u_state     = u_reg;
  assign bus.busy        = busy_c;
  assign bus.done        = done_r;
  assign bus.spike_valid = spike_valid_r;
  assign bus.spike_time  = spike_time_r;

endmodule

// File: tb/tb_neuron_state_seq.sv
// Randomized bench for neuron_state_seq with v_equation stubbed by driven values;
// expectations come from an arithmetic model of the neuron update rules.
module tb_neuron_state_seq;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  neuron_state_seq_if #(.TICK_W(TW)) bus ();

`ifdef SPIKE_COUNT_EN
  logic [15:0] spike_count;
`endif

  neuron_state_seq #(.TICK_W(TW)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef SPIKE_COUNT_EN
    .spike_count (spike_count),
`endif
    .bus         (bus.slave)
  );

  int n_chk = 0;
  int n_bad = 0;

  // Reference neuron state.
  longint mv, mu;
  int     mtick, mcount;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint fdiv(input longint a, input int sh);
    longint p;
    p = longint'(1) << sh;
    if (a >= 0) return a / p;
    return -((-a + p - 1) / p);
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    mv = -650; mu = -130; mtick = 0; mcount = 0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_v"}, bus.v_state, -650);
    chk({tag, "_u"}, bus.u_state, -130);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_svalid"}, bus.spike_valid, 0);
    chk({tag, "_stime"}, bus.spike_time, 0);
`ifdef SPIKE_COUNT_EN
    chk({tag, "_count"}, spike_count, 0);
`endif
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus.step = 1'b0;
    bus.spike_ready = 1'b0;
    cyc();
    cyc();
    model_reset();
    check_reset_state(tag);
    rst = 1'b0;
  endtask

  // One full update: step, EVAL, UPDATE, then retire or hold the event for 'wait_n' cycles.
  task automatic run_step(input int i_val, input int vout, input bit spk, input int wait_n);
    int t_exp;
    bus.step      = 1'b1;
    bus.I_in      = 11'(i_val);
    bus.veq_v_out = vout;
    bus.veq_spike = spk;
    cyc();
    bus.step = 1'b0;
    bus.I_in = ~bus.I_in;
    chk("eval_busy", bus.busy, 1);
    chk("eval_veq_I", bus.veq_I, i_val);
    chk("eval_veq_v", bus.veq_v, mv);
    chk("eval_veq_u", bus.veq_u, mu);
    cyc();
    chk("update_veq_I", bus.veq_I, i_val);
    cyc();
    if (spk) mu = mu + 80;
    else     mu = mu + fdiv(fdiv(mv, 2) - mu, 6);
    mv    = vout;
    t_exp = mtick;
    mtick = (mtick + 1) % (1 << TW);
    chk("v_state", bus.v_state, mv);
    chk("u_state", bus.u_state, mu);
    if (!spk) begin
      chk("done_pulse", bus.done, 1);
      chk("idle_busy", bus.busy, 0);
      chk("no_spike_valid", bus.spike_valid, 0);
      bus.step = 1'b1;
      cyc();
      bus.step = 1'b0;
      chk("done_low", bus.done, 0);
      chk("step_at_done_ignored", bus.busy, 0);
    end else begin
      chk("spike_valid_up", bus.spike_valid, 1);
      chk("spike_time", bus.spike_time, t_exp);
      chk("emit_no_done", bus.done, 0);
      for (int w = 0; w < wait_n; w++) begin
        bus.step = 1'b1;
        bus.I_in = 11'($urandom);
        cyc();
        chk("hold_valid", bus.spike_valid, 1);
        chk("hold_time", bus.spike_time, t_exp);
        chk("hold_busy", bus.busy, 1);
        chk("hold_v", bus.v_state, mv);
      end
      bus.step = 1'b0;
      bus.spike_ready = 1'b1;
      cyc();
      bus.spike_ready = 1'b0;
      if (mcount < 65535) mcount++;
      chk("hs_valid_drop", bus.spike_valid, 0);
      chk("hs_done", bus.done, 1);
      chk("hs_busy", bus.busy, 0);
`ifdef SPIKE_COUNT_EN
      chk("spike_count", spike_count, mcount);
`endif
      cyc();
      chk("hs_done_low", bus.done, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.step = 1'b0;
    bus.I_in = '0;
    bus.veq_v_out = '0;
    bus.veq_spike = 1'b0;
    bus.spike_ready = 1'b0;
    @(negedge clk);

    do_reset("rst");

    // Directed: quiet update then a held spike.
    run_step(5, 100, 0, 0);
    chk("dir_v100", bus.v_state, 100);
    chk("dir_u131", bus.u_state, -131);
    run_step(-3, -650, 1, 3);
    chk("dir_u51", bus.u_state, -51);
    chk("dir_stime1", bus.spike_time, 1);

    // Timestamp wrap: 16 quiet steps then a spike on the 17th.
    do_reset("rst_wrap");
    for (int n = 0; n < 16; n++)
      run_step(int'($urandom_range(2047)) - 1024, int'($urandom_range(4000)) - 2000, 0, 0);
    run_step(1, -650, 1, 0);
    chk("wrap_stime0", bus.spike_time, 0);

    // Reset while in EVAL drops the step.
    bus.step = 1'b1;
    bus.I_in = 11'sd9;
    bus.veq_spike = 1'b1;
    cyc();
    bus.step = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    model_reset();
    check_reset_state("rst_eval");
    cyc();
    chk("rst_eval_idle", bus.busy, 0);
    chk("rst_eval_nodone", bus.done, 0);

    // Reset while an event is pending, with a coinciding handshake.
    bus.step = 1'b1;
    bus.veq_v_out = -650;
    bus.veq_spike = 1'b1;
    cyc();
    bus.step = 1'b0;
    cyc();
    cyc();
    chk("pend_valid", bus.spike_valid, 1);
    rst = 1'b1;
    bus.spike_ready = 1'b1;
    cyc();
    rst = 1'b0;
    bus.spike_ready = 1'b0;
    model_reset();
    check_reset_state("rst_emit");
    cyc();
    chk("rst_emit_lost", bus.spike_valid, 0);
    chk("rst_emit_nodone", bus.done, 0);

    // Randomized mix of quiet and spiking updates with variable backpressure.
    for (int n = 0; n < 60; n++)
      run_step(int'($urandom_range(2047)) - 1024,
               int'($urandom_range(6000)) - 3000,
               ($urandom_range(2) == 0),
               int'($urandom_range(3)));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
